// File: rtl/sramlike_axi_mp_bridge.sv
// Multi-port SRAM-like to AXI3 bridge: one read slot and one write slot, AXI id = port index.
// Define AXI_BRIDGE_RR_EN for round-robin arbitration; otherwise fixed priority, highest index wins.

module sramlike_axi_mp_bridge_port #(
  parameter int ID_W = 4,
  parameter int PIDX = 0
) (
  input  logic            req_i,
  input  logic            wr_i,
  input  logic [29:0]     word_i,
  input  logic            rd_busy_i,
  input  logic [ID_W-1:0] rd_own_i,
  input  logic            wr_busy_i,
  input  logic [ID_W-1:0] wr_own_i,
  input  logic [29:0]     wr_word_i,
  output logic            elig_o
);
  logic inflight, raw;

  assign inflight = (rd_busy_i && rd_own_i == ID_W'(PIDX)) ||
                    (wr_busy_i && wr_own_i == ID_W'(PIDX));
  // a read to the word of a pending write waits until that write has its response
  assign raw      = wr_busy_i && (wr_word_i == word_i);
  assign elig_o   = req_i && !inflight && (wr_i ? !wr_busy_i : (!rd_busy_i && !raw));
endmodule

module sramlike_axi_mp_bridge #(
  parameter int NP   = 2,
  parameter int ID_W = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NP-1:0]         req_i,
  input  logic [NP-1:0]         wr_i,
  input  logic [NP-1:0][1:0]    size_i,
  input  logic [NP-1:0][31:0]   addr_i,
  input  logic [NP-1:0][31:0]   wdata_i,
  output logic [NP-1:0]         addr_ok_o,
  output logic [NP-1:0]         data_ok_o,
  output logic [31:0]           rdata_o,
  output logic [ID_W-1:0]       arid_o,
  output logic [31:0]           araddr_o,
  output logic [7:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic [1:0]            arburst_o,
  output logic [1:0]            arlock_o,
  output logic [3:0]            arcache_o,
  output logic [2:0]            arprot_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [ID_W-1:0]       rid_i,
  input  logic [31:0]           rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  output logic [ID_W-1:0]       awid_o,
  output logic [31:0]           awaddr_o,
  output logic [7:0]            awlen_o,
  output logic [2:0]            awsize_o,
  output logic [1:0]            awburst_o,
  output logic [1:0]            awlock_o,
  output logic [3:0]            awcache_o,
  output logic [2:0]            awprot_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [ID_W-1:0]       wid_o,
  output logic [31:0]           wdata_o,
  output logic [3:0]            wstrb_o,
  output logic                  wlast_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [ID_W-1:0]       bid_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  output logic                  err_o
);
  typedef struct packed {
    logic            busy;
    logic [ID_W-1:0] own;
    logic [31:0]     addr;
    logic [1:0]      size;
  } slot_t;

  slot_t       rd_q, rd_d, wr_q, wr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        arv_q, arv_d, awv_q, awv_d, wv_q, wv_d, err_q, err_d;

  logic [NP-1:0]   elig;
  logic            gnt_vld;
  logic [ID_W-1:0] gnt_idx;
  logic            sel_wr;
  logic [1:0]      sel_size;
  logic [31:0]     sel_addr, sel_wdata;
  logic            rd_cmpl, wr_cmpl;
  logic            unused_ok;

  for (genvar p = 0; p < NP; p++) begin : g_port
    sramlike_axi_mp_bridge_port #(.ID_W(ID_W), .PIDX(p)) u_port (
      .req_i     (req_i[p]),
      .wr_i      (wr_i[p]),
      .word_i    (addr_i[p][31:2]),
      .rd_busy_i (rd_q.busy),
      .rd_own_i  (rd_q.own),
      .wr_busy_i (wr_q.busy),
      .wr_own_i  (wr_q.own),
      .wr_word_i (wr_q.addr[31:2]),
      .elig_o    (elig[p])
    );
  end

`ifdef AXI_BRIDGE_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [2*NP-1:0] elig2;

  // scan from the pointer upward, wrapping; the doubled vector avoids a modulo index
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    elig2   = {elig, elig};
    for (int s = 0; s < NP; s++) begin
      if (ptr_q == ID_W'(s)) begin
        for (int k = 0; k < NP; k++) begin
          if (!gnt_vld && elig2[s+k]) begin
            gnt_vld = 1'b1;
            gnt_idx = ID_W'((s + k) % NP);
          end
        end
      end
    end
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == ID_W'(NP-1)) ? '0 : gnt_idx + ID_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int p = 0; p < NP; p++) begin
      if (elig[p]) begin
        gnt_vld = 1'b1;
        gnt_idx = ID_W'(p);
      end
    end
  end
`endif

  always_comb begin
    sel_wr    = 1'b0;
    sel_size  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    addr_ok_o = '0;
    for (int p = 0; p < NP; p++) begin
      if (gnt_vld && gnt_idx == ID_W'(p)) begin
        addr_ok_o[p] = 1'b1;
        sel_wr       = wr_i[p];
        sel_size     = size_i[p];
        sel_addr     = addr_i[p];
        sel_wdata    = wdata_i[p];
      end
    end
  end

  // a response only completes a slot once its address/data handshakes are done
  assign rd_cmpl = rd_q.busy && !arv_q && rvalid_i && (rid_i == rd_q.own);
  assign wr_cmpl = wr_q.busy && !awv_q && !wv_q && bvalid_i && (bid_i == wr_q.own);

  always_comb begin
    data_ok_o = '0;
    for (int p = 0; p < NP; p++)
      data_ok_o[p] = (rd_cmpl && rd_q.own == ID_W'(p)) || (wr_cmpl && wr_q.own == ID_W'(p));
  end

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    wdat_d = wdat_q;
    arv_d  = arv_q && !arready_i;
    awv_d  = awv_q && !awready_i;
    wv_d   = wv_q && !wready_i;
    err_d  = err_q || (rvalid_i && rresp_i != 2'b00) || (bvalid_i && bresp_i != 2'b00);
    if (rd_cmpl) rd_d.busy = 1'b0;
    if (wr_cmpl) wr_d.busy = 1'b0;
    if (gnt_vld && !sel_wr) begin
      rd_d  = '{busy: 1'b1, own: gnt_idx, addr: sel_addr, size: sel_size};
      arv_d = 1'b1;
    end
    if (gnt_vld && sel_wr) begin
      wr_d   = '{busy: 1'b1, own: gnt_idx, addr: sel_addr, size: sel_size};
      wdat_d = sel_wdata;
      awv_d  = 1'b1;
      wv_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q   <= '0;
      wr_q   <= '0;
      wdat_q <= '0;
      arv_q  <= 1'b0;
      awv_q  <= 1'b0;
      wv_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      wdat_q <= wdat_d;
      arv_q  <= arv_d;
      awv_q  <= awv_d;
      wv_q   <= wv_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    case (wr_q.size)
      2'd0:    wstrb_o = 4'b0001 << wr_q.addr[1:0];
      2'd1:    wstrb_o = 4'b0011 << wr_q.addr[1:0];
      default: wstrb_o = 4'b1111;
    endcase
  end

  assign rdata_o   = rdata_i;
  assign err_o     = err_q;
  assign unused_ok = rlast_i;

  assign arid_o    = rd_q.own;
  assign araddr_o  = rd_q.addr;
  assign arlen_o   = 8'd0;
  assign arsize_o  = {1'b0, rd_q.size};
  assign arburst_o = 2'b01;
  assign arlock_o  = 2'b00;
  assign arcache_o = 4'b0000;
  assign arprot_o  = 3'b000;
  assign arvalid_o = arv_q;
  assign rready_o  = 1'b1;

  assign awid_o    = wr_q.own;
  assign awaddr_o  = wr_q.addr;
  assign awlen_o   = 8'd0;
  assign awsize_o  = {1'b0, wr_q.size};
  assign awburst_o = 2'b01;
  assign awlock_o  = 2'b00;
  assign awcache_o = 4'b0000;
  assign awprot_o  = 3'b000;
  assign awvalid_o = awv_q;
  assign wid_o     = wr_q.own;
  assign wdata_o   = wdat_q;
  assign wlast_o   = 1'b1;
  assign wvalid_o  = wv_q;
  assign bready_o  = 1'b1;
endmodule
